decode_stage: RTL and testbench

Registered, parametrised RV32 instruction decode stage sitting between fetch and execute. It decodes the base integer ISA and optionally the M extension. It generates the sign-extended immediate and register addresses, and flags illegal encodings. Upstream and downstream use a valid/ready handshake through a 2-entry skid buffer, so `o_ready` never depends combinationally on `i_ready`.

---
 rtl/decode_pkg.sv | 104 ++++++++++
 rtl/decode_logic.sv | 141 ++++++++++++++
 rtl/decode_stage.sv | 105 ++++++++++
 tb/tb_decode_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32 decode stage.
// Holds the ALU/immediate/operand/writeback encodings, the RV32 opcode constants, the control
// bundle handed to execute (ctrl_t), the skid-buffer entry (dec_t) and the immediate generator.
package decode_pkg;

  typedef enum logic [4:0] {
    AluAdd    = 5'd0,
    AluSub    = 5'd1,
    AluAnd    = 5'd2,
    AluOr     = 5'd3,
    AluXor    = 5'd4,
    AluSll    = 5'd5,
    AluSrl    = 5'd6,
    AluSra    = 5'd7,
    AluSlt    = 5'd8,
    AluSltu   = 5'd9,
    AluMul    = 5'd10,
    AluMulh   = 5'd11,
    AluMulhsu = 5'd12,
    AluMulhu  = 5'd13,
    AluDiv    = 5'd14,
    AluDivu   = 5'd15,
    AluRem    = 5'd16,
    AluRemu   = 5'd17
  } alu_op_e;

  typedef enum logic [2:0] {
    ImmI = 3'd0,
    ImmS = 3'd1,
    ImmB = 3'd2,
    ImmU = 3'd3,
    ImmJ = 3'd4
  } imm_sel_e;

  typedef enum logic {
    OpaRs1 = 1'b0,
    OpaPc  = 1'b1
  } opa_sel_e;

  typedef enum logic [1:0] {
    OpbRs2  = 2'd0,
    OpbImm  = 2'd1,
    OpbFour = 2'd2
  } opb_sel_e;

  typedef enum logic [1:0] {
    WbAlu  = 2'd0,
    WbLoad = 2'd1,
    WbPc4  = 2'd2
  } wb_sel_e;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mext = 7'b0000001;

  typedef struct packed {
    alu_op_e  alu_op;
    logic     reg_we;
    logic     mem_we;
    logic     mem_re;
    imm_sel_e imm_sel;
    logic     pc_src_branch;
    logic     pc_src_jal;
    logic     pc_src_jalr;
    opa_sel_e opa_sel;
    opb_sel_e opb_sel;
    logic     br_un;
    wb_sel_e  wb_sel;
    logic     insn_vld;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    ctrl_t       ctrl;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_sel_e sel);
    logic [31:0] imm;
    case (sel)
      ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm = {instr[31:12], 12'b0};
      ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Purely combinational RV32I(+M) decoder and immediate generator.
// Ports: instr (instruction word) in; rd/rs1/rs2 register addresses, imm (sign-extended
// immediate), ctrl (control bundle) and illegal out. Illegal encodings zero the whole ctrl.
module decode_logic
  import decode_pkg::*;
#(
  parameter bit EN_MEXT = 1'b1
) (
  input  logic [31:0] instr,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign rd  = instr[11:7];
  assign rs1 = (opcode == OpcLui) ? 5'd0 : instr[19:15];
  assign rs2 = instr[24:20];
  assign imm = gen_imm(instr, ctrl.imm_sel);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OpcLui: begin
        ctrl.reg_we  = 1'b1;
        ctrl.imm_sel = ImmU;
        ctrl.opb_sel = OpbImm;
      end
      OpcAuipc: begin
        ctrl.reg_we  = 1'b1;
        ctrl.imm_sel = ImmU;
        ctrl.opa_sel = OpaPc;
        ctrl.opb_sel = OpbImm;
      end
      OpcJal: begin
        // ALU forms the target (pc + imm); rd receives pc + 4 via the writeback mux.
        ctrl.reg_we     = 1'b1;
        ctrl.imm_sel    = ImmJ;
        ctrl.opa_sel    = OpaPc;
        ctrl.opb_sel    = OpbImm;
        ctrl.pc_src_jal = 1'b1;
        ctrl.wb_sel     = WbPc4;
      end
      OpcJalr: begin
        ctrl.reg_we      = 1'b1;
        ctrl.imm_sel     = ImmI;
        ctrl.opb_sel     = OpbImm;
        ctrl.pc_src_jalr = 1'b1;
        ctrl.wb_sel      = WbPc4;
        illegal          = (funct3 != 3'b000);
      end
      OpcBranch: begin
        ctrl.imm_sel       = ImmB;
        ctrl.pc_src_branch = 1'b1;
        ctrl.br_un         = funct3[1];
        ctrl.alu_op        = funct3[2] ? (funct3[1] ? AluSltu : AluSlt) : AluSub;
        illegal            = (funct3[2:1] == 2'b01);
      end
      OpcLoad: begin
        ctrl.reg_we  = 1'b1;
        ctrl.mem_re  = 1'b1;
        ctrl.imm_sel = ImmI;
        ctrl.opb_sel = OpbImm;
        ctrl.wb_sel  = WbLoad;
        illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OpcStore: begin
        ctrl.mem_we  = 1'b1;
        ctrl.imm_sel = ImmS;
        ctrl.opb_sel = OpbImm;
        illegal      = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OpcOpImm: begin
        ctrl.reg_we  = 1'b1;
        ctrl.imm_sel = ImmI;
        ctrl.opb_sel = OpbImm;
        case (funct3)
          3'b000: ctrl.alu_op = AluAdd;
          3'b001: begin
            ctrl.alu_op = AluSll;
            illegal     = (funct7 != F7Base);
          end
          3'b010: ctrl.alu_op = AluSlt;
          3'b011: ctrl.alu_op = AluSltu;
          3'b100: ctrl.alu_op = AluXor;
          3'b101: begin
            if (funct7 == F7Base)     ctrl.alu_op = AluSrl;
            else if (funct7 == F7Alt) ctrl.alu_op = AluSra;
            else                      illegal     = 1'b1;
          end
          3'b110: ctrl.alu_op = AluOr;
          default: ctrl.alu_op = AluAnd;
        endcase
      end
      OpcOp: begin
        ctrl.reg_we = 1'b1;
        case (funct7)
          F7Base: begin
            case (funct3)
              3'b000: ctrl.alu_op = AluAdd;
              3'b001: ctrl.alu_op = AluSll;
              3'b010: ctrl.alu_op = AluSlt;
              3'b011: ctrl.alu_op = AluSltu;
              3'b100: ctrl.alu_op = AluXor;
              3'b101: ctrl.alu_op = AluSrl;
              3'b110: ctrl.alu_op = AluOr;
              default: ctrl.alu_op = AluAnd;
            endcase
          end
          F7Alt: begin
            if (funct3 == 3'b000)      ctrl.alu_op = AluSub;
            else if (funct3 == 3'b101) ctrl.alu_op = AluSra;
            else                       illegal     = 1'b1;
          end
          F7Mext: begin
            // M-extension ops are laid out contiguously from MUL in funct3 order.
            if (EN_MEXT) ctrl.alu_op = alu_op_e'(5'd10 + {2'b00, funct3});
            else         illegal     = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) ctrl = '0;
    else         ctrl.insn_vld = 1'b1;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage with a 2-entry skid buffer between fetch and execute.
// Ports: i_clk, i_rst_n (async active-low), i_flush; upstream i_valid/o_ready/i_instr/i_pc;
// downstream o_valid/i_ready and the decoded bundle o_pc, o_rd, o_rs1, o_rs2, o_imm, o_ctrl,
// o_illegal. o_ready is registered, so it never depends combinationally on i_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter bit          EN_MEXT  = 1'b1,
  parameter int unsigned ALU_OP_W = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [31:0] o_imm,
  output ctrl_t       o_ctrl,
  output logic        o_illegal
);

  if (ALU_OP_W < 5) begin : g_alu_op_w_check
    $error("ALU_OP_W must be at least 5");
  end

  dec_t       entry_d;
  dec_t       buf_q [2];
  dec_t       head;
  logic       head_q, tail_q;
  logic [1:0] count_q, count_d;
  logic       ready_q;
  logic       push, pop;

  decode_logic #(
    .EN_MEXT(EN_MEXT)
  ) u_decode (
    .instr  (i_instr),
    .rd     (entry_d.rd),
    .rs1    (entry_d.rs1),
    .rs2    (entry_d.rs2),
    .imm    (entry_d.imm),
    .ctrl   (entry_d.ctrl),
    .illegal(entry_d.illegal)
  );
  assign entry_d.pc = i_pc;

  // Flush overrides both transfers: nothing is written and nothing counts as consumed.
  always_comb begin
    push    = i_valid & ready_q & ~i_flush;
    pop     = o_valid & i_ready & ~i_flush;
    count_d = count_q;
    if (i_flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b1;
    end else begin
      if (i_flush) begin
        head_q <= 1'b0;
        tail_q <= 1'b0;
      end else begin
        if (push) begin
          buf_q[tail_q] <= entry_d;
          tail_q        <= ~tail_q;
        end
        if (pop) head_q <= ~head_q;
      end
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
    end
  end

  assign head      = buf_q[head_q];
  assign o_valid   = (count_q != 2'd0);
  assign o_ready   = ready_q;
  assign o_pc      = head.pc;
  assign o_rd      = head.rd;
  assign o_rs1     = head.rs1;
  assign o_rs2     = head.rs2;
  assign o_imm     = head.imm;
  assign o_ctrl    = head.ctrl;
  assign o_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver pushes hand-computed expectations on each
// accepted instruction, the monitor pops and compares whenever an output transfer occurs.
// A second instance built without the M extension runs in lockstep on the same inputs.
module tb_decode_stage;
  import decode_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          chk_imm;
    logic [4:0]  alu;
    bit          chk_alu;
    bit          reg_we, mem_we, mem_re, br, jal, jalr, br_un;
    bit          opa;
    logic [1:0]  opb, wb;
    bit          illegal, nm_illegal;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid, rdy;
  logic [31:0] instr, pc;
  logic        d_ready, d_valid, d_illegal;
  logic [31:0] d_pc, d_imm;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  ctrl_t       d_ctrl;
  logic        n_ready, n_valid, n_illegal;
  logic [31:0] n_pc, n_imm;
  logic [4:0]  n_rd, n_rs1, n_rs2;
  ctrl_t       n_ctrl;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;
  exp_t        exp_q[$];
  exp_t        e;
  vec_t        vecs[15];

  always #5 clk = ~clk;

  decode_stage #(.EN_MEXT(1'b1), .ALU_OP_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(d_ready),
    .i_instr(instr), .i_pc(pc), .o_valid(d_valid), .i_ready(rdy), .o_pc(d_pc), .o_rd(d_rd),
    .o_rs1(d_rs1), .o_rs2(d_rs2), .o_imm(d_imm), .o_ctrl(d_ctrl), .o_illegal(d_illegal)
  );

  decode_stage #(.EN_MEXT(1'b0), .ALU_OP_W(5)) dut_nm (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(n_ready),
    .i_instr(instr), .i_pc(pc), .o_valid(n_valid), .i_ready(rdy), .o_pc(n_pc), .o_rd(n_rd),
    .o_rs1(n_rs1), .o_rs2(n_rs2), .o_imm(n_imm), .o_ctrl(n_ctrl), .o_illegal(n_illegal)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  function automatic vec_t mk(
      input logic [31:0] ins, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input bit chk_imm, input logic [4:0] alu, input bit chk_alu,
      input bit reg_we, input bit mem_we, input bit mem_re, input bit br, input bit jal,
      input bit jalr, input bit br_un, input bit opa, input logic [1:0] opb,
      input logic [1:0] wb, input bit ill, input bit nm_ill);
    vec_t v;
    v.instr = ins; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.chk_imm = chk_imm;
    v.alu = alu; v.chk_alu = chk_alu; v.reg_we = reg_we; v.mem_we = mem_we; v.mem_re = mem_re;
    v.br = br; v.jal = jal; v.jalr = jalr; v.br_un = br_un; v.opa = opa; v.opb = opb;
    v.wb = wb; v.illegal = ill; v.nm_illegal = nm_ill;
    return v;
  endfunction

  // Monitor: a transfer happens at the next rising edge when valid & ready hold now.
  always @(negedge clk) begin
    if (rst_n && d_valid && rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got pc %h, expected no output", d_pc);
      end else begin
        e = exp_q.pop_front();
        n_out++;
        cmp("pc", d_pc, e.pc);
        cmp("rd", 32'(d_rd), 32'(e.v.rd));
        cmp("rs1", 32'(d_rs1), 32'(e.v.rs1));
        cmp("rs2", 32'(d_rs2), 32'(e.v.rs2));
        if (e.v.chk_imm) cmp("imm", d_imm, e.v.imm);
        if (e.v.chk_alu) cmp("alu_op", 32'(d_ctrl.alu_op), 32'(e.v.alu));
        cmp("reg_we", 32'(d_ctrl.reg_we), 32'(e.v.reg_we));
        cmp("mem_we", 32'(d_ctrl.mem_we), 32'(e.v.mem_we));
        cmp("mem_re", 32'(d_ctrl.mem_re), 32'(e.v.mem_re));
        cmp("pc_src_branch", 32'(d_ctrl.pc_src_branch), 32'(e.v.br));
        cmp("pc_src_jal", 32'(d_ctrl.pc_src_jal), 32'(e.v.jal));
        cmp("pc_src_jalr", 32'(d_ctrl.pc_src_jalr), 32'(e.v.jalr));
        cmp("br_un", 32'(d_ctrl.br_un), 32'(e.v.br_un));
        cmp("opa_sel", 32'(d_ctrl.opa_sel), 32'(e.v.opa));
        cmp("opb_sel", 32'(d_ctrl.opb_sel), 32'(e.v.opb));
        cmp("wb_sel", 32'(d_ctrl.wb_sel), 32'(e.v.wb));
        cmp("illegal", 32'(d_illegal), 32'(e.v.illegal));
        cmp("insn_vld", 32'(d_ctrl.insn_vld), 32'(!e.v.illegal));
        cmp("nm_valid", 32'(n_valid), 32'd1);
        cmp("nm_illegal", 32'(n_illegal), 32'(e.v.nm_illegal));
        cmp("nm_reg_we", 32'(n_ctrl.reg_we), 32'(e.v.reg_we && !e.v.nm_illegal));
      end
    end
  end

  task automatic send(input int idx, output int stalls);
    exp_t t;
    stalls = 0;
    valid  = 1'b1;
    instr  = vecs[idx].instr;
    pc     = pc_ctr;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (d_ready) begin
        t.v = vecs[idx];
        t.pc = pc_ctr;
        exp_q.push_back(t);
        pc_ctr += 32'd4;
        @(posedge clk);
        #1;
        valid = 1'b0;
        return;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL send_timeout: got no o_ready in 64 cycles, expected acceptance");
    valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    cmp("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot, n0;
    logic [31:0] pc_a;
    //          instr          rd  rs1 rs2 imm            ci alu ca we mw mr br jl jr bu a opb wb il nm
    vecs[0]  = mk(32'h00500093, 1,  0,  5, 32'd5,          1, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(32'h123450B7, 1,  0,  3, 32'h12345000,   1, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(32'h0020E463, 8,  1,  2, 32'd8,          1, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(32'h022081B3, 3,  1,  2, 32'd0,          0, 10, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[4]  = mk(32'h407302B3, 5,  6,  7, 32'd0,          0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(32'hFFC1A103, 2,  3, 28, 32'hFFFFFFFC,   1, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[6]  = mk(32'h00512423, 8,  2,  5, 32'd8,          1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(32'hFFDFF06F, 0, 31, 29, 32'hFFFFFFFC,   1, 0,  1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 2, 0, 0);
    vecs[8]  = mk(32'h000290E7, 1,  5,  0, 32'd0,          0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[9]  = mk(32'h40001093, 1,  0,  0, 32'd0,          0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[10] = mk(32'h4041D113, 2,  3,  4, 32'd1028,       1, 7,  1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[11] = mk(32'hFFFFFFFF, 31, 31, 31, 32'd0,         0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[12] = mk(32'h00001217, 4,  0,  0, 32'h00001000,   1, 0,  1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[13] = mk(32'h003140B3, 1,  2,  3, 32'd0,          0, 4,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(32'h027352B3, 5,  6,  7, 32'd0,          0, 15, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    rst_n = 1'b1; flush = 1'b0; valid = 1'b0; instr = '0; pc = '0; rdy = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    cmp("reset_valid", 32'(d_valid), 32'd0);
    cmp("reset_ready", 32'(d_ready), 32'd1);
    cmp("reset_pc", d_pc, 32'd0);
    cmp("reset_ctrl", 32'(d_ctrl), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // Single instruction into an empty buffer: valid one cycle after acceptance.
    send(0, st);
    @(negedge clk);
    cmp("latency_valid", 32'(d_valid), 32'd1);
    @(posedge clk) #1;

    // Back-to-back stream with no backpressure: never stalls.
    tot = 0;
    for (int i = 1; i < 15; i++) begin
      send(i, st);
      tot += st;
    end
    cmp("throughput_stalls", 32'(tot), 32'd0);
    drain();

    // Backpressure: four back-to-back instructions, i_ready low for three cycles.
    n0 = n_out;
    pc_a = pc_ctr;
    rdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(i, st);
      end
      begin
        repeat (3) @(negedge clk);
        cmp("bp_ready_full", 32'(d_ready), 32'd0);
        cmp("bp_valid_held", 32'(d_valid), 32'd1);
        cmp("bp_head_stable", d_pc, pc_a);
        @(posedge clk) #1;
        rdy = 1'b1;
        @(negedge clk);
        cmp("bp_ready_before_pop", 32'(d_ready), 32'd0);
      end
    join
    drain();
    cmp("bp_delivered", 32'(n_out - n0), 32'd4);

    // Flush at occupancy 2 with a valid input in the same cycle.
    rdy = 1'b0;
    send(4, st);
    send(6, st);
    valid = 1'b1; instr = vecs[13].instr; pc = 32'hDEAD_0000; flush = 1'b1;
    @(negedge clk);
    cmp("flush2_ready_full", 32'(d_ready), 32'd0);
    @(posedge clk) #1;
    flush = 1'b0; valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    cmp("flush2_valid", 32'(d_valid), 32'd0);
    cmp("flush2_ready", 32'(d_ready), 32'd1);
    @(posedge clk) #1;
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Flush at occupancy 1: the instruction offered in the flush cycle must be dropped.
    rdy = 1'b0;
    send(5, st);
    valid = 1'b1; instr = vecs[13].instr; pc = 32'hDEAD_0004; flush = 1'b1;
    @(negedge clk);
    cmp("flush1_ready", 32'(d_ready), 32'd1);
    @(posedge clk) #1;
    flush = 1'b0; valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    cmp("flush1_valid", 32'(d_valid), 32'd0);
    @(posedge clk) #1;
    rdy = 1'b1;
    send(10, st);
    drain();

    // Asynchronous reset in the middle of a stream with buffered entries.
    rdy = 1'b0;
    send(0, st);
    send(1, st);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    cmp("rst_valid", 32'(d_valid), 32'd0);
    cmp("rst_ready", 32'(d_ready), 32'd1);
    cmp("rst_pc", d_pc, 32'd0);
    cmp("rst_imm", d_imm, 32'd0);
    cmp("rst_regs", {17'd0, d_rd, d_rs1, d_rs2}, 32'd0);
    cmp("rst_ctrl", 32'(d_ctrl), 32'd0);
    cmp("rst_illegal", 32'(d_illegal), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    rdy = 1'b1;
    send(2, st);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
